// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_LATENCY_DEF = 4;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter timing one memory access: loaded on grant, counts to zero.
module mem_latency_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one fixed-latency memory port,
// alternating grants on contention and supporting fetch cancellation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_cancel,
    output logic            if_ready,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ready,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            if_stall,
    output logic            d_stall
);

    arb_state_e      state_q;
    owner_e          owner_q;
    owner_e          last_q;
    logic            drop_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;

    logic serving;
    logic grant_d;
    logic cnt_load;
    logic cnt_zero;

    assign serving  = (state_q == ST_SERVE_I) || (state_q == ST_SERVE_D);
    // Data wins unless fetch is also waiting and data was served last.
    assign grant_d  = d_req && (!if_req || (last_q == OWN_I));
    assign cnt_load = (state_q == ST_IDLE) && (d_req || if_req);

    mem_latency_counter u_cnt (
        .clk        (clk),
        .rst        (reset),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(MEM_LATENCY - 1)),
        .dec_i      (serving),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        owner_q <= OWN_D;
                        addr_q  <= d_addr;
                        we_q    <= d_we;
                        wdata_q <= d_wdata;
                        state_q <= ST_SERVE_D;
                    end else if (if_req) begin
                        owner_q <= OWN_I;
                        addr_q  <= if_addr;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                        state_q <= ST_SERVE_I;
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    if ((state_q == ST_SERVE_I) && if_cancel)
                        drop_q <= 1'b1;
                    if (cnt_zero) begin
                        rdata_q <= mem_rdata;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    last_q  <= owner_q;
                    drop_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_valid = serving;
    assign mem_we    = serving && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // A cancel arriving in the response cycle itself must still swallow the pulse.
    assign if_ready = (state_q == ST_RESP) && (owner_q == OWN_I) && !drop_q && !if_cancel;
    assign d_ready  = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign if_rdata = rdata_q;
    assign d_rdata  = rdata_q;

    assign if_stall = if_req && !if_ready;
    assign d_stall  = d_req && !d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized contention.
module tb_mem_port_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_cancel, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ready, d_ready, mem_valid, mem_we, if_stall, d_stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic        grant_log[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h40) return 32'h00A00093;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign mem_rdata = memf(mem_addr);

    mem_port_arbiter #(.MEM_LATENCY(L), .XLEN(32)) dut (
        .clk(clk), .reset(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .d_stall(d_stall)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    // Monitor: pops scoreboard entries on ready pulses, models arbitration at each grant.
    initial begin : monitor
        logic        was_valid, p_if, p_d, last_d, exp_d, got_d, g_we;
        logic [31:0] g_addr, g_wdata;
        int          run;
        was_valid = 0; p_if = 0; p_d = 0; last_d = 0; run = 0;
        g_we = 0; g_addr = 0; g_wdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                was_valid = 0; p_if = 0; p_d = 0; last_d = 0; run = 0;
            end else begin
                if (if_ready) begin
                    check("if_ready_has_request", 32'(if_q.size() > 0), 32'd1);
                    if (if_q.size() > 0) check("if_rdata", if_rdata, if_q.pop_front());
                end
                if (d_ready) begin
                    check("d_ready_has_request", 32'(d_q.size() > 0), 32'd1);
                    if (d_q.size() > 0) check("d_rdata", d_rdata, d_q.pop_front());
                end
                check("if_stall", 32'(if_stall), 32'(if_req && !if_ready));
                check("d_stall", 32'(d_stall), 32'(d_req && !d_ready));
                if (!mem_valid) check("mem_we_when_idle", 32'(mem_we), 32'd0);
                if (mem_valid && !was_valid) begin
                    exp_d = p_d && (!p_if || !last_d);
                    got_d = d_req && (mem_addr == d_addr);
                    check("grant_owner_is_data", 32'(got_d), 32'(exp_d));
                    g_addr  = exp_d ? d_addr : if_addr;
                    g_we    = exp_d ? d_we : 1'b0;
                    g_wdata = d_wdata;
                    check("grant_we", 32'(mem_we), 32'(g_we));
                    last_d = exp_d;
                    grant_log.push_back(got_d);
                    run = 0;
                end
                if (mem_valid) begin
                    run++;
                    check("mem_addr_held", mem_addr, g_addr);
                    if (g_we) check("mem_wdata_held", mem_wdata, g_wdata);
                end
                if (!mem_valid && was_valid) check("serve_cycles", 32'(run), 32'(L));
                was_valid = mem_valid;
                p_if = if_req;
                p_d  = d_req;
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, input int gap, output int lat);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back(memf(a));
        n = 0;
        do begin @(negedge clk); n++; end while (!if_ready && n < 200);
        check("if_completes", 32'(if_ready), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        lat = n;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input int gap, output int lat);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        d_q.push_back(memf(a));
        n = 0;
        do begin @(negedge clk); n++; end while (!d_ready && n < 200);
        check("d_completes", 32'(d_ready), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        lat = n;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_valid && n < 20);
        check("access_started", 32'(mem_valid), 32'd1);
    endtask

    initial begin : stim
        int lat_i, lat_d;
        rst = 1'b1; if_req = 0; if_cancel = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        #3;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", if_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Tie right after reset: data first, then fetch.
        grant_log.delete();
        fork
            do_fetch(32'h0000_0080, 0, lat_i);
            do_data(1'b0, 32'h0000_0100, 32'h0, 0, lat_d);
        join
        check("tie_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("tie_first_data", 32'(grant_log[0]), 32'd1);
            check("tie_second_fetch", 32'(grant_log[1]), 32'd0);
        end

        // Lone fetch with known instruction word and latency.
        do_fetch(32'h0000_0040, 1, lat_i);
        check("fetch_latency", 32'(lat_i), 32'(L + 2));
        check("fetch_insn", if_rdata, 32'h00A00093);

        // Store.
        do_data(1'b1, 32'h0000_0200, 32'hDEADBEEF, 1, lat_d);
        check("store_latency", 32'(lat_d), 32'(L + 2));

        // Cancel in second SERVE_I cycle; inputs changed afterwards must be ignored.
        @(posedge clk); #1;
        if_addr = 32'h0000_00C0;
        if_req  = 1'b1;
        if_q.push_back(memf(32'h0000_00C0));
        wait_valid();
        @(posedge clk); #1;
        if_cancel = 1'b1;
        void'(if_q.pop_back());
        if_addr = 32'h0000_0F00;
        @(posedge clk); #1;
        if_cancel = 1'b0;
        if_req    = 1'b0;
        repeat (L + 3) @(posedge clk);
        #1;
        do_fetch(32'h0000_00C4, 0, lat_i);
        check("post_cancel_latency", 32'(lat_i), 32'(L + 2));

        // Reset in third SERVE_D cycle aborts the access.
        d_we = 1'b0; d_addr = 32'h0000_0300; d_req = 1'b1;
        d_q.push_back(memf(32'h0000_0300));
        wait_valid();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_mem_valid", 32'(mem_valid), 32'd0);
        check("abort_d_ready", 32'(d_ready), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        d_req = 1'b0;
        d_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_data(1'b0, 32'h0000_0304, 32'h0, 1, lat_d);
        check("post_reset_latency", 32'(lat_d), 32'(L + 2));

        // Cancel seen while idle has no effect on the fetch granted from that cycle.
        fork
            do_fetch(32'h0000_0044, 0, lat_i);
            begin if_cancel = 1'b1; @(posedge clk); #1; if_cancel = 1'b0; end
        join

        // Continuous contention: strict alternation.
        grant_log.delete();
        fork
            begin for (int i = 0; i < 4; i++) do_fetch(32'h0000_0400 + 32'(i * 4), 0, lat_i); end
            begin for (int j = 0; j < 4; j++) do_data(1'(j), 32'h8000_0400 + 32'(j * 4), $urandom, 0, lat_d); end
        join
        check("contention_grants", 32'(grant_log.size()), 32'd8);
        for (int k = 1; k < grant_log.size(); k++)
            check("grants_alternate", 32'(grant_log[k] != grant_log[k-1]), 32'd1);

        // Randomized mix.
        fork
            begin
                for (int i = 0; i < 30; i++)
                    do_fetch({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom_range(0, 3), lat_i);
            end
            begin
                for (int j = 0; j < 30; j++)
                    do_data(1'($urandom_range(0, 1)), {1'b1, 19'h0, 10'($urandom_range(0, 1023)), 2'b00},
                            $urandom, $urandom_range(0, 3), lat_d);
            end
        join
        repeat (3) @(posedge clk);
        check("if_scoreboard_empty", 32'(if_q.size()), 32'd0);
        check("d_scoreboard_empty", 32'(d_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, memory access cycles (legal range 1..15).
REQ-002 SHALL have parameter XLEN, default 32, address/data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  fetch-stage read request, held until if_ready.
REQ-006 SHALL have port if_addr  input  XLEN  fetch address.
REQ-007 SHALL have port if_cancel  input  1  discard in-flight fetch on branch mispredict.
REQ-008 SHALL have port if_ready  output  1  one-cycle pulse: if_rdata valid.
REQ-009 SHALL have port if_rdata  output  XLEN  fetched instruction.
REQ-010 SHALL have port d_req  input  1  MEM-stage request (load or store), held until d_ready.
REQ-011 SHALL have port d_we, d_addr, d_wdata  input  1/XLEN/XLEN  store flag, address, store data.
REQ-012 SHALL have port d_ready  output  1  one-cycle pulse: data access complete.
REQ-013 SHALL have port d_rdata  output  XLEN  load data.
REQ-014 SHALL have port mem_valid, mem_we, mem_addr, mem_wdata  output  1/1/XLEN/XLEN  unified memory command.
REQ-015 SHALL have port mem_rdata  input  XLEN  memory read data, valid in final access cycle.
REQ-016 SHALL have port if_stall, d_stall  output  1  pipeline stall requests to the hazard/control logic.

Function
REQ-017 SHALL implement FSM IDLE, SERVE_I, SERVE_D, RESP.
REQ-018 IDLE: d_req and if_req both high -> grant opposite of last_grant (starts with data priority); single request -> grant it; none -> stay.
REQ-019 On grant SHALL latch owner, addr, we (0 for fetch), wdata; load counter MEM_LATENCY-1; enter SERVE_I/SERVE_D.
REQ-020 SERVE_x: mem_valid=1, mem_* driven from latched values only; requester input changes ignored.
REQ-021 SERVE_x: counter decrements each cycle; at counter 0 SHALL capture mem_rdata into response register, enter RESP.
REQ-022 RESP: SHALL pulse owner's ready for exactly one cycle, update last_grant to owner, return to IDLE.
REQ-023 Request-to-ready latency SHALL be MEM_LATENCY+1 cycles after the grant edge; IDLE lasts at least one cycle between accesses.
REQ-024 if_rdata and d_rdata SHALL both present the response register; contents hold until next capture.
REQ-025 Store SHALL still pulse d_ready; d_rdata then equals captured mem_rdata (don't care).
REQ-026 if_cancel high in SERVE_I or RESP(fetch) SHALL set a drop flag; memory access completes but if_ready is suppressed; flag clears on return to IDLE.
REQ-027 if_cancel in IDLE or during data service SHALL have no effect.
REQ-028 if_stall = if_req & ~if_ready; d_stall = d_req & ~d_ready (combinational).
REQ-029 mem_valid SHALL be 0 in IDLE and RESP; mem_we SHALL be 0 whenever mem_valid is 0.

Reset
REQ-030 reset SHALL force IDLE asynchronously, including mid-access; memory command aborted.
REQ-031 Reset values: mem_valid/mem_we/if_ready/d_ready 0, mem_addr/mem_wdata/response register 0, counter 0, last_grant = fetch (so data wins first tie), drop flag 0.

Structure
REQ-032 State encoding, owner enum and default MEM_LATENCY SHALL live in shared package mem_arb_pkg.
REQ-033 Counter SHALL be a sub-module mem_latency_counter (load, decrement, zero flag).

Verification
REQ-034 MEM_LATENCY=4, lone if_req addr 0x40, mem_rdata 0x00A00093 -> mem_valid 4 cycles, if_ready 1 cycle, if_rdata 0x00A00093.
REQ-035 if_req and d_req (load 0x100) same cycle after reset -> data served first; fetch granted next IDLE; if_stall high throughout.
REQ-036 Store d_addr 0x200, d_wdata 0xDEADBEEF -> mem_we=1 with those values 4 cycles, d_ready pulse, no if_ready.
REQ-037 if_cancel pulse in second SERVE_I cycle -> access completes, if_ready never asserts, next if_req served normally.
REQ-038 reset asserted in third SERVE_D cycle -> mem_valid 0 immediately, no d_ready; post-reset request completes normally.
REQ-039 Continuous if_req and d_req for 40 cycles -> grants strictly alternate, no ready pulse without matching request.
